// File: rtl/serial_full_adder.sv
// -----------------------------------------------------------------------------
// serial_full_adder
//
// Bit-serial WIDTH-bit adder. A single full-adder cell, built from two
// half-adder stages, is reused once per bit over WIDTH clock cycles. A carry
// flop links one bit to the next. A start/busy/done handshake frames each
// operation.
//
// Optional feature (compile-time macro SERIAL_FULL_ADDER_SUB_EN):
//    When the macro is defined, the design gains a 'sub' input that is captured
//    with the operands. With sub=1 the design computes in1 - in2. It does this
//    by inverting B on capture and forcing the initial carry to 1. A carry_out
//    of 1 then means that no borrow occurred.
//
// Parameters:
//    WIDTH      operand/result width, legal range 2..64 (default 4)
//    CNT_W      bit counter width, derived from WIDTH (not overridable)
//
// Ports:
//    clk        rising-edge clock
//    rst        asynchronous, active-high reset
//    start      request, sampled only in IDLE or DONE
//    in1        operand A, captured on the accepting edge
//    in2        operand B, captured on the accepting edge
//    carry_in   initial carry, captured on the accepting edge
//    sub        (SERIAL_FULL_ADDER_SUB_EN only) subtract select
//    busy       high while an operation is running
//    done       one-cycle completion pulse
//    sum        result register, updated only on completion
//    carry_out  final carry (bit WIDTH of the result)
// -----------------------------------------------------------------------------
module serial_full_adder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             carry_in,
`ifdef SERIAL_FULL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_shift;
   logic [CNT_W-1:0] cnt;
   logic             carry_q;

   logic             accept;
   logic             last_bit;

   logic [WIDTH-1:0] b_init;
   logic             carry_init;

   logic             ha1_sum;
   logic             ha1_carry;
   logic             ha2_sum;
   logic             ha2_carry;
   logic             bit_carry;
   logic [WIDTH-1:0] next_shift;

   // The state register is the only place that reacts to reset for control.
   // Because busy/done are decoded from it, they drop immediately on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake decode. 'accept' marks an edge that captures
   // new operands, whether from IDLE or back-to-back from DONE. 'last_bit'
   // marks the edge that processes the final bit and publishes the result.
   // A start that arrives while in RUN is ignored on purpose.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      last_bit   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               next_state = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST_CNT) begin
               last_bit   = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               accept     = 1'b1;
               next_state = RUN;
            end else begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Operand conditioning at capture time. Subtraction is done as
   // A + ~B + 1, so the adder datapath itself never changes.
   always_comb begin
      b_init     = in2;
      carry_init = carry_in;
`ifdef SERIAL_FULL_ADDER_SUB_EN
      if (sub) begin
         b_init     = ~in2;
         carry_init = 1'b1;
      end
`endif
   end

   // One full-adder cell built from two half adders. The first half adder
   // combines the operand LSBs. The second half adder folds in the carry
   // left over from the previous bit.
   always_comb begin
      ha1_sum    = a_reg[0] ^ b_reg[0];
      ha1_carry  = a_reg[0] & b_reg[0];
      ha2_sum    = ha1_sum ^ carry_q;
      ha2_carry  = ha1_sum & carry_q;
      bit_carry  = ha1_carry | ha2_carry;
      // Result bits enter at the MSB and move right. After WIDTH shifts, the
      // first bit computed sits at position 0.
      next_shift = {ha2_sum, {(WIDTH-1){1'b0}}} | (sum_shift >> 1);
   end

   // Serial datapath: operand shifters, carry flop, bit counter, and the
   // result register. sum/carry_out change only on completion, so a reader
   // sees a stable previous result for the whole of the next operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sum_shift <= '0;
         cnt       <= '0;
         carry_q   <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
      end else if (accept) begin
         a_reg     <= in1;
         b_reg     <= b_init;
         sum_shift <= '0;
         cnt       <= '0;
         carry_q   <= carry_init;
      end else if (state == RUN) begin
         a_reg     <= a_reg >> 1;
         b_reg     <= b_reg >> 1;
         sum_shift <= next_shift;
         carry_q   <= bit_carry;
         cnt       <= cnt + CNT_W'(1);
         if (last_bit) begin
            sum       <= next_shift;
            carry_out <= bit_carry;
         end
      end
   end

endmodule
